// File: rtl/multicycle_ctrl.sv
// Multicycle processor control unit: FETCH/DECODE/EXECUTE/MEM_ACCESS/WRITEBACK
// sequencing with illegal-opcode, overflow and memory-timeout traps.
module multicycle_ctrl #(
   parameter int MEM_TIMEOUT = 15,
   parameter int TYPE_W      = 4,
   parameter bit EN_OVF_TRAP = 1'b1
) (
   input  logic              CLK,
   input  logic              RES_N,
   input  logic [6:0]        opcode,
   input  logic              overflow,
   input  logic              memReady,
   input  logic              stall,
   output logic              instWrite,
   output logic              regWrite,
   output logic              aluSrcA,
   output logic              memRead,
   output logic              memWrite,
   output logic              memToReg,
   output logic              isFetch,
   output logic              isJump,
   output logic              isBranch,
   output logic [1:0]        aluSrcB,
   output logic [TYPE_W-1:0] instType,
   output logic              trap,
   output logic [1:0]        trapCause,
   output logic [2:0]        state
);

   typedef enum logic [2:0] {
      S_FETCH     = 3'b001,
      S_DECODE    = 3'b010,
      S_EXECUTE   = 3'b011,
      S_MEM       = 3'b100,
      S_WRITEBACK = 3'b101,
      S_TRAP      = 3'b110
   } state_t;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   localparam logic [3:0] T_NONE  = 4'd0;
   localparam logic [3:0] T_R     = 4'd1;
   localparam logic [3:0] T_I     = 4'd2;
   localparam logic [3:0] T_JALR  = 4'd3;
   localparam logic [3:0] T_LOAD  = 4'd4;
   localparam logic [3:0] T_STORE = 4'd5;
   localparam logic [3:0] T_B     = 4'd6;
   localparam logic [3:0] T_JAL   = 4'd7;
   localparam logic [3:0] T_LUI   = 4'd8;
   localparam logic [3:0] T_AUIPC = 4'd9;

   localparam logic [1:0] C_ILLEGAL = 2'b01;
   localparam logic [1:0] C_OVF     = 2'b10;
   localparam logic [1:0] C_TIMEOUT = 2'b11;

   localparam logic [7:0] LP_TIMEOUT = 8'(MEM_TIMEOUT);

   state_t     r_state;
   state_t     w_state_next;
   logic [7:0] r_wait;
   logic [7:0] w_wait_inc;
   logic [1:0] r_cause;
   logic [1:0] w_cause_next;
   logic [3:0] w_type;
   logic       w_is_load;
   logic       w_is_store;
   logic       w_is_arith;
   logic       w_timeout;
   logic       w_counting;

   always_comb begin
      w_type = T_NONE;
      case (opcode)
         OP_R:     w_type = T_R;
         OP_I:     w_type = T_I;
         OP_JALR:  w_type = T_JALR;
         OP_LOAD:  w_type = T_LOAD;
         OP_STORE: w_type = T_STORE;
         OP_B:     w_type = T_B;
         OP_JAL:   w_type = T_JAL;
         OP_LUI:   w_type = T_LUI;
         OP_AUIPC: w_type = T_AUIPC;
         default:  w_type = T_NONE;
      endcase
   end

   assign w_is_load  = (w_type == T_LOAD);
   assign w_is_store = (w_type == T_STORE);
   assign w_is_arith = (w_type == T_R) || (w_type == T_I);

   // Timeout fires on the cycle whose increment would reach MEM_TIMEOUT,
   // so exactly MEM_TIMEOUT waiting cycles are spent before the trap.
   assign w_wait_inc = r_wait + 8'd1;
   assign w_timeout  = !memReady && (w_wait_inc == LP_TIMEOUT);
   assign w_counting = ((r_state == S_FETCH) || (r_state == S_MEM)) && !memReady && !stall;

   always_comb begin
      w_state_next = r_state;
      w_cause_next = r_cause;
      case (r_state)
         S_FETCH: begin
            if (!stall) begin
               if (memReady) begin
                  w_state_next = S_DECODE;
               end else if (w_timeout) begin
                  w_state_next = S_TRAP;
                  w_cause_next = C_TIMEOUT;
               end
            end
         end
         S_DECODE: begin
            if (!stall) begin
               if (w_type == T_NONE) begin
                  w_state_next = S_TRAP;
                  w_cause_next = C_ILLEGAL;
               end else begin
                  w_state_next = S_EXECUTE;
               end
            end
         end
         S_EXECUTE: begin
            if (!stall) begin
               if (w_type == T_B) begin
                  w_state_next = S_FETCH;
               end else if (w_is_load || w_is_store) begin
                  w_state_next = S_MEM;
               end else if (EN_OVF_TRAP && overflow && w_is_arith) begin
                  w_state_next = S_TRAP;
                  w_cause_next = C_OVF;
               end else begin
                  w_state_next = S_WRITEBACK;
               end
            end
         end
         S_MEM: begin
            if (!stall) begin
               if (!(w_is_load || w_is_store)) begin
                  w_state_next = S_FETCH;
               end else if (memReady) begin
                  w_state_next = w_is_load ? S_WRITEBACK : S_FETCH;
               end else if (w_timeout) begin
                  w_state_next = S_TRAP;
                  w_cause_next = C_TIMEOUT;
               end
            end
         end
         S_WRITEBACK: begin
            if (!stall) begin
               w_state_next = S_FETCH;
            end
         end
         S_TRAP:  w_state_next = S_FETCH;
         default: w_state_next = S_FETCH;
      endcase
   end

   always_ff @(posedge CLK or negedge RES_N) begin
      if (!RES_N) begin
         r_state <= S_FETCH;
         r_wait  <= 8'd0;
         r_cause <= 2'b00;
      end else begin
         r_state <= w_state_next;
         if (w_state_next != r_state) begin
            r_wait <= 8'd0;
         end else if (w_counting) begin
            r_wait <= w_wait_inc;
         end
         if ((w_state_next == S_TRAP) && (r_state != S_TRAP)) begin
            r_cause <= w_cause_next;
         end
      end
   end

   always_comb begin
      instWrite = 1'b0;
      regWrite  = 1'b0;
      aluSrcA   = 1'b0;
      memRead   = 1'b0;
      memWrite  = 1'b0;
      memToReg  = 1'b0;
      isFetch   = 1'b0;
      isJump    = 1'b0;
      isBranch  = 1'b0;
      aluSrcB   = 2'b00;
      instType  = '0;
      trap      = 1'b0;
      case (r_state)
         S_FETCH: begin
            isFetch   = 1'b1;
            memRead   = 1'b1;
            instWrite = memReady;
         end
         S_EXECUTE: begin
            instType = TYPE_W'(w_type);
            case (w_type)
               T_I, T_LOAD, T_STORE, T_LUI: aluSrcB = 2'b01;
               T_JALR, T_JAL: begin
                  aluSrcA = 1'b1;
                  aluSrcB = 2'b10;
                  isJump  = 1'b1;
               end
               T_B: isBranch = 1'b1;
               T_AUIPC: begin
                  aluSrcA = 1'b1;
                  aluSrcB = 2'b01;
               end
               default: ;
            endcase
         end
         S_MEM: begin
            memRead  = w_is_load;
            memWrite = w_is_store;
         end
         S_WRITEBACK: begin
            regWrite = 1'b1;
            memToReg = w_is_load;
         end
         S_TRAP:  trap = 1'b1;
         default: ;
      endcase
      // Write strobes must never fire while frozen or while reset is held.
      if ((stall && (r_state != S_TRAP)) || !RES_N) begin
         regWrite  = 1'b0;
         memWrite  = 1'b0;
         instWrite = 1'b0;
      end
   end

   assign trapCause = r_cause;
   assign state     = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scenario bench for multicycle_ctrl: per-cycle expected outputs are queued as
// stimulus is driven and popped/compared at the falling edge.
module tb_multicycle_ctrl;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_BAD   = 7'b1111111;

   // Control-vector bit weights: {iw,rw,srcA,mr,mw,m2r,fetch,jump,branch,srcB[1:0],trap}
   localparam logic [11:0] C_IW  = 12'h800;
   localparam logic [11:0] C_RW  = 12'h400;
   localparam logic [11:0] C_SA  = 12'h200;
   localparam logic [11:0] C_MR  = 12'h100;
   localparam logic [11:0] C_MW  = 12'h080;
   localparam logic [11:0] C_M2R = 12'h040;
   localparam logic [11:0] C_IF  = 12'h020;
   localparam logic [11:0] C_J   = 12'h010;
   localparam logic [11:0] C_BR  = 12'h008;
   localparam logic [11:0] C_B10 = 12'h004;
   localparam logic [11:0] C_B01 = 12'h002;
   localparam logic [11:0] C_TR  = 12'h001;

   typedef struct {
      logic [6:0]  opc;
      logic        mr;
      logic        ovf;
      logic        stl;
      logic [20:0] exp;
   } row_t;

   logic       CLK = 1'b0;
   logic       RES_N = 1'b1;
   logic [6:0] opcode = 7'd0;
   logic       overflow = 1'b0;
   logic       memReady = 1'b0;
   logic       stall = 1'b0;

   logic instWrite, regWrite, aluSrcA, memRead, memWrite, memToReg, isFetch, isJump, isBranch, trap;
   logic [1:0] aluSrcB, trapCause;
   logic [3:0] instType;
   logic [2:0] state;

   logic n_instWrite, n_regWrite, n_aluSrcA, n_memRead, n_memWrite, n_memToReg;
   logic n_isFetch, n_isJump, n_isBranch, n_trap;
   logic [1:0] n_aluSrcB, n_trapCause;
   logic [3:0] n_instType;
   logic [2:0] n_state;

   logic [20:0] obs, obs2;
   logic [20:0] exp_q[$];
   int n_vec = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   multicycle_ctrl dut (
      .CLK(CLK), .RES_N(RES_N), .opcode(opcode), .overflow(overflow),
      .memReady(memReady), .stall(stall), .instWrite(instWrite), .regWrite(regWrite),
      .aluSrcA(aluSrcA), .memRead(memRead), .memWrite(memWrite), .memToReg(memToReg),
      .isFetch(isFetch), .isJump(isJump), .isBranch(isBranch), .aluSrcB(aluSrcB),
      .instType(instType), .trap(trap), .trapCause(trapCause), .state(state)
   );

   multicycle_ctrl #(.EN_OVF_TRAP(1'b0)) dut_novf (
      .CLK(CLK), .RES_N(RES_N), .opcode(opcode), .overflow(overflow),
      .memReady(memReady), .stall(stall), .instWrite(n_instWrite), .regWrite(n_regWrite),
      .aluSrcA(n_aluSrcA), .memRead(n_memRead), .memWrite(n_memWrite), .memToReg(n_memToReg),
      .isFetch(n_isFetch), .isJump(n_isJump), .isBranch(n_isBranch), .aluSrcB(n_aluSrcB),
      .instType(n_instType), .trap(n_trap), .trapCause(n_trapCause), .state(n_state)
   );

   assign obs  = {state, instType, trapCause, instWrite, regWrite, aluSrcA, memRead, memWrite,
                  memToReg, isFetch, isJump, isBranch, aluSrcB, trap};
   assign obs2 = {n_state, n_instType, n_trapCause, n_instWrite, n_regWrite, n_aluSrcA, n_memRead,
                  n_memWrite, n_memToReg, n_isFetch, n_isJump, n_isBranch, n_aluSrcB, n_trap};

   function automatic row_t rw(input logic [6:0] opc, input logic mr, input logic ovf,
                               input logic stl, input logic [2:0] st, input logic [3:0] it,
                               input logic [1:0] cs, input logic [11:0] ctl);
      row_t r;
      r.opc = opc;
      r.mr  = mr;
      r.ovf = ovf;
      r.stl = stl;
      r.exp = {st, it, cs, ctl};
      return r;
   endfunction

   task automatic drive(input row_t r);
      opcode   = r.opc;
      memReady = r.mr;
      overflow = r.ovf;
      stall    = r.stl;
      exp_q.push_back(r.exp);
   endtask

   task automatic test_reset();
      logic [20:0] e;
      opcode = OP_R;
      memReady = 1'b1;
      #1 RES_N = 1'b0;
      exp_q.push_back({3'd1, 4'd0, 2'd0, C_IF | C_MR});
      #1 e = exp_q.pop_front();
      n_vec++;
      if (obs !== e) begin
         n_err++;
         $display("FAIL reset_init got=%h exp=%h", obs, e);
      end
      @(posedge CLK) #2;
      exp_q.push_back({3'd1, 4'd0, 2'd0, C_IF | C_MR});
      e = exp_q.pop_front();
      n_vec++;
      if (obs !== e) begin
         n_err++;
         $display("FAIL reset_held got=%h exp=%h", obs, e);
      end
      memReady = 1'b0;
      @(negedge CLK) RES_N = 1'b1;
      @(posedge CLK) #1;
   endtask

   task automatic test_add();
      row_t seq[$];
      logic [20:0] e;
      seq.push_back(rw(OP_R, 1, 0, 0, 3'd1, 4'd0, 2'd0, C_IF | C_MR | C_IW));
      seq.push_back(rw(OP_R, 1, 0, 0, 3'd2, 4'd0, 2'd0, 12'h000));
      seq.push_back(rw(OP_R, 1, 0, 0, 3'd3, 4'd1, 2'd0, 12'h000));
      seq.push_back(rw(OP_R, 1, 0, 0, 3'd5, 4'd0, 2'd0, C_RW));
      foreach (seq[i]) begin
         drive(seq[i]);
         @(negedge CLK);
         e = exp_q.pop_front();
         n_vec++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL add cyc%0d got=%h exp=%h", i, obs, e);
         end
         @(posedge CLK) #1;
      end
   endtask

   task automatic test_load_wait();
      row_t seq[$];
      logic [20:0] e;
      seq.push_back(rw(OP_LOAD, 1, 0, 0, 3'd1, 4'd0, 2'd0, C_IF | C_MR | C_IW));
      seq.push_back(rw(OP_LOAD, 1, 0, 0, 3'd2, 4'd0, 2'd0, 12'h000));
      seq.push_back(rw(OP_LOAD, 1, 0, 0, 3'd3, 4'd4, 2'd0, C_B01));
      for (int k = 0; k < 3; k++) seq.push_back(rw(OP_LOAD, 0, 0, 0, 3'd4, 4'd0, 2'd0, C_MR));
      seq.push_back(rw(OP_LOAD, 1, 0, 0, 3'd4, 4'd0, 2'd0, C_MR));
      seq.push_back(rw(OP_LOAD, 1, 0, 0, 3'd5, 4'd0, 2'd0, C_RW | C_M2R));
      foreach (seq[i]) begin
         drive(seq[i]);
         @(negedge CLK);
         e = exp_q.pop_front();
         n_vec++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL load_wait cyc%0d got=%h exp=%h", i, obs, e);
         end
         @(posedge CLK) #1;
      end
   endtask

   task automatic test_illegal();
      row_t seq[$];
      logic [20:0] e;
      seq.push_back(rw(OP_BAD, 1, 0, 0, 3'd1, 4'd0, 2'd0, C_IF | C_MR | C_IW));
      seq.push_back(rw(OP_BAD, 1, 0, 0, 3'd2, 4'd0, 2'd0, 12'h000));
      seq.push_back(rw(OP_BAD, 1, 0, 0, 3'd6, 4'd0, 2'd1, C_TR));
      foreach (seq[i]) begin
         drive(seq[i]);
         @(negedge CLK);
         e = exp_q.pop_front();
         n_vec++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL illegal cyc%0d got=%h exp=%h", i, obs, e);
         end
         @(posedge CLK) #1;
      end
   endtask

   task automatic test_overflow();
      row_t seq[$];
      logic [20:0] e2[$];
      logic [20:0] e, f;
      seq.push_back(rw(OP_I, 1, 0, 0, 3'd1, 4'd0, 2'd1, C_IF | C_MR | C_IW));
      seq.push_back(rw(OP_I, 1, 0, 0, 3'd2, 4'd0, 2'd1, 12'h000));
      seq.push_back(rw(OP_I, 1, 1, 0, 3'd3, 4'd2, 2'd1, C_B01));
      seq.push_back(rw(OP_I, 1, 0, 0, 3'd6, 4'd0, 2'd2, C_TR));
      e2.push_back({3'd1, 4'd0, 2'd1, C_IF | C_MR | C_IW});
      e2.push_back({3'd2, 4'd0, 2'd1, 12'h000});
      e2.push_back({3'd3, 4'd2, 2'd1, C_B01});
      e2.push_back({3'd5, 4'd0, 2'd1, C_RW});
      foreach (seq[i]) begin
         drive(seq[i]);
         @(negedge CLK);
         e = exp_q.pop_front();
         f = e2.pop_front();
         n_vec += 2;
         if (obs !== e) begin
            n_err++;
            $display("FAIL ovf_trap cyc%0d got=%h exp=%h", i, obs, e);
         end
         if (obs2 !== f) begin
            n_err++;
            $display("FAIL ovf_notrap cyc%0d got=%h exp=%h", i, obs2, f);
         end
         @(posedge CLK) #1;
      end
   endtask

   task automatic test_exec_types();
      logic [6:0]  ops[6] = '{OP_JALR, OP_B, OP_JAL, OP_LUI, OP_AUIPC, OP_I};
      logic [3:0]  its[6] = '{4'd3, 4'd6, 4'd7, 4'd8, 4'd9, 4'd2};
      logic [11:0] cts[6] = '{C_SA | C_B10 | C_J, C_BR, C_SA | C_B10 | C_J, C_B01, C_SA | C_B01, C_B01};
      logic        ovs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      row_t seq[$];
      logic [20:0] e;
      for (int k = 0; k < 6; k++) begin
         seq.push_back(rw(ops[k], 1, 0, 0, 3'd1, 4'd0, 2'd2, C_IF | C_MR | C_IW));
         seq.push_back(rw(ops[k], 1, 0, 0, 3'd2, 4'd0, 2'd2, 12'h000));
         seq.push_back(rw(ops[k], 1, ovs[k], 0, 3'd3, its[k], 2'd2, cts[k]));
         if (ops[k] != OP_B) seq.push_back(rw(ops[k], 1, 0, 0, 3'd5, 4'd0, 2'd2, C_RW));
      end
      foreach (seq[i]) begin
         drive(seq[i]);
         @(negedge CLK);
         e = exp_q.pop_front();
         n_vec++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL exec_types cyc%0d op=%b got=%h exp=%h", i, seq[i].opc, obs, e);
         end
         @(posedge CLK) #1;
      end
   endtask

   task automatic test_stall_fetch_timeout();
      row_t seq[$];
      logic [20:0] e;
      for (int k = 0; k < 2; k++) seq.push_back(rw(OP_R, 1, 0, 1, 3'd1, 4'd0, 2'd2, C_IF | C_MR));
      for (int k = 0; k < 14; k++) seq.push_back(rw(OP_R, 0, 0, 0, 3'd1, 4'd0, 2'd2, C_IF | C_MR));
      seq.push_back(rw(OP_R, 1, 0, 0, 3'd1, 4'd0, 2'd2, C_IF | C_MR | C_IW));
      seq.push_back(rw(OP_R, 1, 0, 0, 3'd2, 4'd0, 2'd2, 12'h000));
      seq.push_back(rw(OP_R, 1, 0, 0, 3'd3, 4'd1, 2'd2, 12'h000));
      seq.push_back(rw(OP_R, 1, 0, 1, 3'd5, 4'd0, 2'd2, 12'h000));
      seq.push_back(rw(OP_R, 1, 0, 0, 3'd5, 4'd0, 2'd2, C_RW));
      for (int k = 0; k < 15; k++) seq.push_back(rw(OP_R, 0, 0, 0, 3'd1, 4'd0, 2'd2, C_IF | C_MR));
      seq.push_back(rw(OP_R, 0, 0, 1, 3'd6, 4'd0, 2'd3, C_TR));
      foreach (seq[i]) begin
         drive(seq[i]);
         @(negedge CLK);
         e = exp_q.pop_front();
         n_vec++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL stall_fetch_to cyc%0d got=%h exp=%h", i, obs, e);
         end
         @(posedge CLK) #1;
      end
   endtask

   task automatic test_store();
      row_t seq[$];
      logic [20:0] e;
      seq.push_back(rw(OP_STORE, 1, 0, 0, 3'd1, 4'd0, 2'd3, C_IF | C_MR | C_IW));
      seq.push_back(rw(OP_STORE, 1, 0, 0, 3'd2, 4'd0, 2'd3, 12'h000));
      for (int k = 0; k < 5; k++) seq.push_back(rw(OP_STORE, 1, 0, 1, 3'd3, 4'd5, 2'd3, C_B01));
      seq.push_back(rw(OP_STORE, 1, 0, 0, 3'd3, 4'd5, 2'd3, C_B01));
      for (int k = 0; k < 15; k++) seq.push_back(rw(OP_STORE, 0, 0, 0, 3'd4, 4'd0, 2'd3, C_MW));
      seq.push_back(rw(OP_STORE, 0, 0, 0, 3'd6, 4'd0, 2'd3, C_TR));
      seq.push_back(rw(OP_STORE, 1, 0, 0, 3'd1, 4'd0, 2'd3, C_IF | C_MR | C_IW));
      seq.push_back(rw(OP_STORE, 1, 0, 0, 3'd2, 4'd0, 2'd3, 12'h000));
      seq.push_back(rw(OP_STORE, 1, 0, 0, 3'd3, 4'd5, 2'd3, C_B01));
      seq.push_back(rw(OP_STORE, 1, 0, 1, 3'd4, 4'd0, 2'd3, 12'h000));
      seq.push_back(rw(OP_STORE, 1, 0, 0, 3'd4, 4'd0, 2'd3, C_MW));
      foreach (seq[i]) begin
         drive(seq[i]);
         @(negedge CLK);
         e = exp_q.pop_front();
         n_vec++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL store cyc%0d got=%h exp=%h", i, obs, e);
         end
         @(posedge CLK) #1;
      end
   endtask

   task automatic test_reset_mid();
      row_t seq[$];
      row_t post[$];
      logic [20:0] e;
      seq.push_back(rw(OP_STORE, 1, 0, 0, 3'd1, 4'd0, 2'd3, C_IF | C_MR | C_IW));
      seq.push_back(rw(OP_STORE, 1, 0, 0, 3'd2, 4'd0, 2'd3, 12'h000));
      seq.push_back(rw(OP_STORE, 1, 0, 0, 3'd3, 4'd5, 2'd3, C_B01));
      seq.push_back(rw(OP_STORE, 0, 0, 0, 3'd4, 4'd0, 2'd3, C_MW));
      seq.push_back(rw(OP_STORE, 0, 0, 0, 3'd4, 4'd0, 2'd3, C_MW));
      foreach (seq[i]) begin
         drive(seq[i]);
         @(negedge CLK);
         e = exp_q.pop_front();
         n_vec++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL reset_mid_pre cyc%0d got=%h exp=%h", i, obs, e);
         end
         @(posedge CLK) #1;
      end
      memReady = 1'b1;
      exp_q.push_back({3'd1, 4'd0, 2'd0, C_IF | C_MR});
      #1 RES_N = 1'b0;
      #1 e = exp_q.pop_front();
      n_vec++;
      if (obs !== e) begin
         n_err++;
         $display("FAIL reset_async got=%h exp=%h", obs, e);
      end
      @(posedge CLK) #2;
      exp_q.push_back({3'd1, 4'd0, 2'd0, C_IF | C_MR});
      e = exp_q.pop_front();
      n_vec++;
      if (obs !== e) begin
         n_err++;
         $display("FAIL reset_mid_hold got=%h exp=%h", obs, e);
      end
      memReady = 1'b0;
      @(negedge CLK) RES_N = 1'b1;
      @(posedge CLK) #1;
      post.push_back(rw(OP_STORE, 0, 0, 0, 3'd1, 4'd0, 2'd0, C_IF | C_MR));
      post.push_back(rw(OP_STORE, 1, 0, 0, 3'd1, 4'd0, 2'd0, C_IF | C_MR | C_IW));
      post.push_back(rw(OP_STORE, 1, 0, 0, 3'd2, 4'd0, 2'd0, 12'h000));
      foreach (post[i]) begin
         drive(post[i]);
         @(negedge CLK);
         e = exp_q.pop_front();
         n_vec++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL reset_mid_post cyc%0d got=%h exp=%h", i, obs, e);
         end
         @(posedge CLK) #1;
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_load_wait();
      test_illegal();
      test_overflow();
      test_exec_types();
      test_stall_fetch_timeout();
      test_store();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "simulation did not complete");
   end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have parameter MEM_TIMEOUT, default 15: max wait cycles for memReady in FETCH/MEM_ACCESS before bus-error trap (1..255).
REQ-002 The block SHALL have parameter TYPE_W, default 4: width of instType (>=4).
REQ-003 The block SHALL have parameter EN_OVF_TRAP, default 1: 1 = arithmetic overflow on R/I-calc suppresses writeback and traps.
REQ-004 The block SHALL have port CLK  in  1: single clock, rising-edge.
REQ-005 The block SHALL have port RES_N  in  1: reset, asynchronous, active-low.
REQ-006 The block SHALL have port opcode  in  7: current instruction opcode.
REQ-007 The block SHALL have port overflow  in  1: ALU overflow, valid in EXECUTE.
REQ-008 The block SHALL have ports memReady  in  1 (memory access complete this cycle) and stall  in  1 (freeze FSM).
REQ-009 The block SHALL have outputs instWrite, regWrite, aluSrcA, memRead, memWrite, memToReg, isFetch, isJump, isBranch, each  out  1, same meaning as existing control unit.
REQ-010 The block SHALL have outputs aluSrcB  out  2, instType  out  TYPE_W.
REQ-011 The block SHALL have outputs trap  out  1 (one-cycle pulse), trapCause  out  2 (01 illegal, 10 overflow, 11 bus timeout), state  out  3 (debug).

Function
REQ-012 States: FETCH=001, DECODE=010, EXECUTE=011, MEM_ACCESS=100, WRITEBACK=101, TRAP=110; any other encoding SHALL go to FETCH next cycle.
REQ-013 Opcodes: R 0110011, I-calc 0010011, JALR 1100111, LOAD 0000011, STORE 0100011, B 1100011, JAL 1101111, LUI 0110111, AUIPC 0010111; instType codes 1..9 in that order, 0 otherwise.
REQ-014 FETCH: isFetch=1, memRead=1; instWrite=1 only in the cycle memReady=1; advance to DECODE on memReady.
REQ-015 DECODE: unlisted opcode -> TRAP cause 01; else -> EXECUTE; all control outputs 0.
REQ-016 EXECUTE outputs: R: instType only; I-calc/LOAD/STORE: aluSrcB=01; JALR/JAL: aluSrcA=1, aluSrcB=10, isJump=1; B: isBranch=1; LUI: aluSrcB=01; AUIPC: aluSrcA=1, aluSrcB=01.
REQ-017 EXECUTE next: B -> FETCH; LOAD/STORE -> MEM_ACCESS; R/I-calc with overflow=1 and EN_OVF_TRAP=1 -> TRAP cause 10; all others -> WRITEBACK.
REQ-018 MEM_ACCESS: LOAD memRead=1, STORE memWrite=1, held until memReady; then LOAD -> WRITEBACK, STORE -> FETCH.
REQ-019 WRITEBACK: regWrite=1 for one cycle; memToReg=1 for LOAD only; -> FETCH.
REQ-020 Wait counter (8 bit) SHALL clear on entry to FETCH/MEM_ACCESS, increment each cycle memReady=0; when count reaches MEM_TIMEOUT with memReady=0 -> TRAP cause 11; memReady in the same cycle wins over timeout.
REQ-021 TRAP: trap=1, trapCause valid, all other controls 0, exactly one cycle, -> FETCH; trapCause SHALL hold until next trap.
REQ-022 stall=1 SHALL hold state and wait counter and force regWrite, memWrite, instWrite to 0; stall ignored in TRAP.
REQ-023 Control outputs SHALL be combinational from state, opcode, memReady, stall; no latches.

Reset
REQ-024 RES_N=0 SHALL immediately force state=FETCH, wait counter=0, trapCause=00, independent of CLK.
REQ-025 During reset all control outputs except isFetch, memRead SHALL be 0; reset mid-access SHALL abort with no regWrite/memWrite pulse after release.

Verification
REQ-026 ADD (0110011), memReady always 1 -> states 1,2,3,5,1; regWrite high exactly cycle 4.
REQ-027 LOAD, memReady low 3 cycles in MEM_ACCESS -> memRead held 4 cycles, then WRITEBACK with memToReg=1.
REQ-028 Opcode 1111111 -> DECODE to TRAP, trap pulse 1 cycle, trapCause=01, no regWrite.
REQ-029 ADDI with overflow=1 in EXECUTE -> TRAP cause 10, regWrite never asserted; with EN_OVF_TRAP=0 -> WRITEBACK.
REQ-030 STORE, memReady stuck 0, MEM_TIMEOUT=15 -> memWrite 15 cycles then TRAP cause 11; stall=1 in EXECUTE for 5 cycles -> state held 5 cycles.
REQ-031 RES_N low mid-MEM_ACCESS STORE -> state=FETCH asynchronously, memWrite drops same instant.
